// File: rtl/decode_stage.sv
// Decode stage: combinational D-stage decode feeding a registered E-stage control bundle,
// with a small FSM that inserts bubbles behind a multi-cycle MUL.
module decode_stage #(
  parameter int unsigned MUL_CYCLES    = 3,
  parameter bit          CHECK_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        MemtoRegE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        PCSrcE,
  output logic [2:0]  ALUControlE,
  output logic [1:0]  FlagWriteE,
  output logic [3:0]  CondE,
  output logic        ValidE,
  output logic        IllegalE,
  output logic        MulBusy
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       pc_src;
    logic [2:0] alu_ctrl;
    logic [1:0] flag_write;
    logic [3:0] cond;
    logic       valid;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [0:0] {StIdle, StMulB} state_e;

  ctrl_t      dec, e_q;
  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] op;
  logic [5:0] funct;
  logic       illegal, is_mul, is_add_sub, is_cmp, mul_start;
  logic       unused_bits;

  assign op          = InstrD[27:26];
  assign funct       = InstrD[25:20];
  assign unused_bits = ^{InstrD[19:16], InstrD[11:0]};

  always_comb begin
    dec        = '0;
    RegSrcD    = 2'b00;
    ImmSrcD    = 2'b00;
    illegal    = 1'b0;
    is_mul     = 1'b0;
    is_add_sub = 1'b0;
    is_cmp     = 1'b0;
    dec.cond   = InstrD[31:28];
    dec.valid  = 1'b1;
    case (op)
      2'b00: begin
        dec.alu_src   = funct[5];
        dec.reg_write = 1'b1;
        case (funct[4:1])
          4'b0100: begin dec.alu_ctrl = 3'b011; is_add_sub = 1'b1; end
          4'b0010: begin dec.alu_ctrl = 3'b010; is_add_sub = 1'b1; end
          4'b0000: dec.alu_ctrl = 3'b000;
          4'b1100: dec.alu_ctrl = 3'b101;
          4'b1101: dec.alu_ctrl = 3'b001;
          4'b0001: begin dec.alu_ctrl = 3'b110; is_mul = 1'b1; end
          4'b1111: begin dec.alu_ctrl = 3'b100; is_cmp = 1'b1; end
          default: illegal = 1'b1;
        endcase
        dec.flag_write = {funct[0], funct[0] & is_add_sub};
        if (is_cmp) begin
          dec.flag_write = 2'b11;
          dec.reg_write  = 1'b0;
        end
      end
      2'b01: begin
        ImmSrcD      = 2'b01;
        dec.alu_src  = 1'b1;
        dec.alu_ctrl = 3'b011;
        if (funct[0]) begin
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
        end else begin
          RegSrcD       = 2'b10;
          dec.mem_write = 1'b1;
        end
      end
      2'b10: begin
        RegSrcD      = 2'b01;
        ImmSrcD      = 2'b10;
        dec.alu_src  = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_ctrl = 3'b011;
      end
      default: illegal = 1'b1;
    endcase
    // PC redirect is evaluated on the already-gated write enables.
    dec.pc_src = ((InstrD[15:12] == 4'hF) & dec.reg_write) | dec.branch;
    if (illegal) begin
      dec         = '0;
      dec.valid   = CHECK_ILLEGAL;
      dec.illegal = CHECK_ILLEGAL;
    end
    if (!ValidD) dec = '0;
  end

  assign mul_start = ValidD & is_mul & ~illegal & (MUL_CYCLES > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else if (FlushE) begin
      e_q     <= '0;
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else if (!StallE) begin
      if (state_q == StMulB) begin
        e_q <= '0;
        if (cnt_q <= 4'd1) begin
          state_q <= StIdle;
          cnt_q   <= 4'd0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end else begin
        e_q <= dec;
        if (mul_start) begin
          state_q <= StMulB;
          cnt_q   <= 4'(MUL_CYCLES - 1);
        end
      end
    end
  end

  assign MulBusy     = (state_q == StMulB);
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign PCSrcE      = e_q.pc_src;
  assign ALUControlE = e_q.alu_ctrl;
  assign FlagWriteE  = e_q.flag_write;
  assign CondE       = e_q.cond;
  assign ValidE      = e_q.valid;
  assign IllegalE    = e_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus MUL/flush/stall/reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD;
  logic        ValidD, StallE, FlushE;

  logic [1:0] RegSrcD, ImmSrcD, RegSrcD_n, ImmSrcD_n;
  logic       RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, PCSrcE, ValidE, IllegalE, MulBusy;
  logic       RegWriteE_n, MemWriteE_n, MemtoRegE_n, BranchE_n, ALUSrcE_n, PCSrcE_n;
  logic       ValidE_n, IllegalE_n, MulBusy_n;
  logic [2:0] ALUControlE, ALUControlE_n;
  logic [1:0] FlagWriteE, FlagWriteE_n;
  logic [3:0] CondE, CondE_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .PCSrcE(PCSrcE), .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .ValidE(ValidE), .IllegalE(IllegalE), .MulBusy(MulBusy)
  );

  // Second instance: no illegal detection, single-cycle MUL.
  decode_stage #(.MUL_CYCLES(1), .CHECK_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .RegSrcD(RegSrcD_n), .ImmSrcD(ImmSrcD_n), .RegWriteE(RegWriteE_n),
    .MemWriteE(MemWriteE_n), .MemtoRegE(MemtoRegE_n), .BranchE(BranchE_n),
    .ALUSrcE(ALUSrcE_n), .PCSrcE(PCSrcE_n), .ALUControlE(ALUControlE_n),
    .FlagWriteE(FlagWriteE_n), .CondE(CondE_n), .ValidE(ValidE_n), .IllegalE(IllegalE_n),
    .MulBusy(MulBusy_n)
  );

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  regsrc;
    logic [1:0]  immsrc;
    logic [18:0] exp_e; // {rw,mw,m2r,br,alusrc,pcsrc,alu[2:0],fw[1:0],cond[3:0],valid,illegal}
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] mk(logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                                     logic [3:0] rd);
    return {cond, op, funct, 4'h0, rd, 12'h000};
  endfunction

  function automatic vec_t v(logic [31:0] instr, logic valid, logic [1:0] regsrc,
                             logic [1:0] immsrc, logic [5:0] en, logic [2:0] alu,
                             logic [1:0] fw, logic [3:0] cond, logic ve, logic ill);
    vec_t r;
    r.instr  = instr;
    r.valid  = valid;
    r.regsrc = regsrc;
    r.immsrc = immsrc;
    r.exp_e  = {en, alu, fw, cond, ve, ill};
    return r;
  endfunction

  function automatic logic [18:0] e_bus();
    return {RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, PCSrcE, ALUControlE,
            FlagWriteE, CondE, ValidE, IllegalE};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = v(mk(4'hE, 2'b00, 6'b001001, 4'd1),  1, 2'b00, 2'b00, 6'b100000, 3'b011, 2'b11, 4'hE, 1, 0);
    vecs[1]  = v(mk(4'h0, 2'b00, 6'b100100, 4'd2),  1, 2'b00, 2'b00, 6'b100010, 3'b010, 2'b00, 4'h0, 1, 0);
    vecs[2]  = v(mk(4'h1, 2'b00, 6'b000001, 4'd3),  1, 2'b00, 2'b00, 6'b100000, 3'b000, 2'b10, 4'h1, 1, 0);
    vecs[3]  = v(mk(4'hE, 2'b00, 6'b011000, 4'd15), 1, 2'b00, 2'b00, 6'b100001, 3'b101, 2'b00, 4'hE, 1, 0);
    vecs[4]  = v(mk(4'hE, 2'b00, 6'b111010, 4'd6),  1, 2'b00, 2'b00, 6'b100010, 3'b001, 2'b00, 4'hE, 1, 0);
    vecs[5]  = v(mk(4'hE, 2'b00, 6'b011110, 4'd15), 1, 2'b00, 2'b00, 6'b000000, 3'b100, 2'b11, 4'hE, 1, 0);
    vecs[6]  = v(mk(4'hE, 2'b01, 6'b011001, 4'd4),  1, 2'b00, 2'b01, 6'b101010, 3'b011, 2'b00, 4'hE, 1, 0);
    vecs[7]  = v(mk(4'hE, 2'b01, 6'b011000, 4'd4),  1, 2'b10, 2'b01, 6'b010010, 3'b011, 2'b00, 4'hE, 1, 0);
    vecs[8]  = v(mk(4'hE, 2'b10, 6'b100000, 4'd0),  1, 2'b01, 2'b10, 6'b000111, 3'b011, 2'b00, 4'hE, 1, 0);
    vecs[9]  = v(mk(4'hE, 2'b11, 6'b000000, 4'd0),  1, 2'b00, 2'b00, 6'b000000, 3'b000, 2'b00, 4'h0, 1, 1);
    vecs[10] = v(mk(4'hE, 2'b00, 6'b001110, 4'd1),  1, 2'b00, 2'b00, 6'b000000, 3'b000, 2'b00, 4'h0, 1, 1);
    vecs[11] = v(mk(4'hE, 2'b00, 6'b001001, 4'd1),  0, 2'b00, 2'b00, 6'b000000, 3'b000, 2'b00, 4'h0, 0, 0);
    vecs[12] = v(mk(4'h2, 2'b01, 6'b000001, 4'd15), 1, 2'b00, 2'b01, 6'b101011, 3'b011, 2'b00, 4'h2, 1, 0);
    vecs[13] = v(mk(4'hE, 2'b00, 6'b000101, 4'd7),  1, 2'b00, 2'b00, 6'b100000, 3'b010, 2'b11, 4'hE, 1, 0);

    rst_n  = 1'b0;
    InstrD = mk(4'hE, 2'b00, 6'b001001, 4'd1);
    ValidD = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;

    #2;
    chk("reset E bus", 32'(e_bus()), 32'd0);
    chk("reset MulBusy", 32'(MulBusy), 32'd0);
    tick();
    chk("reset held over clk", 32'(e_bus()), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      InstrD = vecs[i].instr;
      ValidD = vecs[i].valid;
      #1;
      chk($sformatf("vec%0d RegSrcD", i), 32'(RegSrcD), 32'(vecs[i].regsrc));
      chk($sformatf("vec%0d ImmSrcD", i), 32'(ImmSrcD), 32'(vecs[i].immsrc));
      tick();
      chk($sformatf("vec%0d E bus", i), 32'(e_bus()), 32'(vecs[i].exp_e));
      chk($sformatf("vec%0d noillegal valid/illegal", i), 32'({ValidE_n, IllegalE_n}),
          32'({vecs[i].exp_e[1] & ~vecs[i].exp_e[0], 1'b0}));
    end

    // MUL, MUL_CYCLES=3: one valid E cycle, then two bubbles behind MulBusy.
    InstrD = mk(4'hE, 2'b00, 6'b000010, 4'd5);
    ValidD = 1'b1;
    tick();
    chk("mul captured valid/alu", 32'({ValidE, ALUControlE, RegWriteE}), 32'({1'b1, 3'b110, 1'b1}));
    chk("mul busy c1", 32'(MulBusy), 32'd1);
    chk("mul1 never busy", 32'(MulBusy_n), 32'd0);
    InstrD = mk(4'hE, 2'b00, 6'b001000, 4'd2);
    tick();
    chk("mul bubble c2", 32'({MulBusy, ValidE, RegWriteE}), 32'({1'b1, 1'b0, 1'b0}));
    chk("mul1 captures next", 32'({MulBusy_n, ValidE_n, ALUControlE_n}), 32'({1'b0, 1'b1, 3'b011}));
    tick();
    chk("mul bubble c3 idle", 32'({MulBusy, ValidE}), 32'd0);
    tick();
    chk("post-mul add", 32'({MulBusy, ValidE, ALUControlE}), 32'({1'b0, 1'b1, 3'b011}));

    // Flush on the first MULB cycle returns to IDLE at once.
    InstrD = mk(4'hE, 2'b00, 6'b000010, 4'd5);
    tick();
    chk("flush setup busy", 32'(MulBusy), 32'd1);
    FlushE = 1'b1;
    InstrD = mk(4'hE, 2'b00, 6'b001000, 4'd2);
    tick();
    chk("flush in mulb", 32'({MulBusy, ValidE, RegWriteE}), 32'd0);
    FlushE = 1'b0;
    tick();
    chk("after flush add", 32'({MulBusy, ValidE, ALUControlE}), 32'({1'b0, 1'b1, 3'b011}));

    // Stall holds both the E register and the MUL counter.
    InstrD = mk(4'hE, 2'b00, 6'b000010, 4'd5);
    tick();
    StallE = 1'b1;
    InstrD = mk(4'hE, 2'b00, 6'b001000, 4'd2);
    tick();
    tick();
    chk("stall holds mul", 32'({MulBusy, ValidE, ALUControlE}), 32'({1'b1, 1'b1, 3'b110}));
    StallE = 1'b0;
    tick();
    chk("unstall bubble 1", 32'({MulBusy, ValidE}), 32'({1'b1, 1'b0}));
    tick();
    chk("unstall bubble 2", 32'({MulBusy, ValidE}), 32'd0);
    tick();
    chk("after stall add", 32'({ValidE, ALUControlE}), 32'({1'b1, 3'b011}));

    // Asynchronous reset mid-MULB.
    InstrD = mk(4'hE, 2'b00, 6'b000010, 4'd5);
    tick();
    InstrD = mk(4'hE, 2'b01, 6'b011000, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset E bus", 32'(e_bus()), 32'd0);
    chk("async reset busy", 32'(MulBusy), 32'd0);
    chk("RegSrcD in reset", 32'({RegSrcD, ImmSrcD}), 32'({2'b10, 2'b01}));
    tick();
    InstrD = mk(4'hE, 2'b00, 6'b001000, 4'd2);
    rst_n  = 1'b1;
    tick();
    chk("add after reset", 32'({MulBusy, ValidE, RegWriteE, ALUControlE}),
        32'({1'b0, 1'b1, 1'b1, 3'b011}));
    tick();
    chk("no residual busy", 32'(MulBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
